// File: rtl/ztex_work_port_master.sv
// ztex_work_port_master: byte-serial initiator that shifts out 352-bit work and fetches 96-bit results.
// Define WORK_PORT_POLL_EN to add an idle timer that starts result fetches automatically.
module ztex_work_port_master #(
    parameter int HOLD = 4
`ifdef WORK_PORT_POLL_EN
    , parameter int POLL_INTERVAL = 1000000
`endif
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [351:0] work,
    input  logic         work_valid,
    output logic         work_ready,
    input  logic         fetch_req,
    output logic [95:0]  result,
    output logic         result_valid,
    output logic         busy,
    output logic [7:0]   port_read,
    output logic         port_rd_clk,
    output logic         port_wr_clk,
    output logic         port_wr_start,
    input  logic [7:0]   port_write
);
    localparam int HW = $clog2(HOLD + 1);

    typedef enum logic [1:0] {IDLE, SEND, LOAD, RECV} state_t;

    state_t         state;
    logic [HW-1:0]  hold;
    logic [5:0]     cnt;
    logic           phase;
    logic [343:0]   wbuf;
    logic [87:0]    rsh;
    logic           hold_done;
    logic           fetch_go;

    assign hold_done  = hold == HW'(HOLD - 1);
    assign work_ready = reset_n && state == IDLE;

`ifdef WORK_PORT_POLL_EN
    logic [31:0] idle_cnt;
    assign fetch_go = fetch_req || idle_cnt == 32'(POLL_INTERVAL);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) idle_cnt <= '0;
        else idle_cnt <= (state == IDLE && !work_valid && !fetch_go) ? idle_cnt + 32'd1 : '0;
`else
    assign fetch_go = fetch_req;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            hold          <= '0;
            cnt           <= '0;
            phase         <= 1'b0;
            wbuf          <= '0;
            rsh           <= '0;
            result        <= '0;
            result_valid  <= 1'b0;
            busy          <= 1'b0;
            port_read     <= '0;
            port_rd_clk   <= 1'b0;
            port_wr_clk   <= 1'b0;
            port_wr_start <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    hold  <= '0;
                    cnt   <= '0;
                    phase <= 1'b0;
                    if (work_valid) begin
                        wbuf      <= work[351:8];
                        port_read <= work[7:0];
                        busy      <= 1'b1;
                        state     <= SEND;
                    end else if (fetch_go) begin
                        port_wr_start <= 1'b1;
                        busy          <= 1'b1;
                        state         <= LOAD;
                    end
                end
                SEND: begin
                    hold <= hold_done ? '0 : hold + 1'b1;
                    // phase 0: byte settles then strobe; phase 1: byte held after strobe
                    if (hold_done) begin
                        phase <= !phase;
                        if (!phase) port_rd_clk <= !port_rd_clk;
                        else if (cnt == 6'd43) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            cnt       <= cnt + 6'd1;
                            port_read <= wbuf[7:0];
                            wbuf      <= wbuf >> 8;
                        end
                    end
                end
                LOAD: begin
                    hold <= hold_done ? '0 : hold + 1'b1;
                    if (hold_done) begin
                        phase <= !phase;
                        if (!phase) port_wr_start <= 1'b0;
                        else begin
                            cnt   <= '0;
                            state <= RECV;
                        end
                    end
                end
                RECV: begin
                    hold <= hold_done ? '0 : hold + 1'b1;
                    if (hold == '0) begin
                        if (cnt == 6'd11) begin
                            result       <= {port_write, rsh};
                            result_valid <= 1'b1;
                            busy         <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            rsh         <= {port_write, rsh[87:8]};
                            port_wr_clk <= !port_wr_clk;
                            cnt         <= cnt + 6'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ztex_work_port_master.sv
// tb_ztex_work_port_master: directed bench with a remote-port model and a timeline model of the master.
// Define WORK_PORT_POLL_EN to run the automatic-poll scenario instead of the directed sequence.
module tb_ztex_work_port_master;
    localparam int H  = 4;
    localparam int PI = 100;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [351:0] work = '0;
    logic         work_valid = 1'b0;
    logic         fetch_req = 1'b0;
    logic         work_ready;
    logic [95:0]  result;
    logic         result_valid;
    logic         busy;
    logic [7:0]   port_read;
    logic         port_rd_clk;
    logic         port_wr_clk;
    logic         port_wr_start;
    logic [7:0]   port_write;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    ztex_work_port_master #(
        .HOLD(H)
`ifdef WORK_PORT_POLL_EN
        , .POLL_INTERVAL(PI)
`endif
    ) dut (
        .clk(clk), .reset_n(reset_n), .work(work), .work_valid(work_valid),
        .work_ready(work_ready), .fetch_req(fetch_req), .result(result),
        .result_valid(result_valid), .busy(busy), .port_read(port_read),
        .port_rd_clk(port_rd_clk), .port_wr_clk(port_wr_clk),
        .port_wr_start(port_wr_start), .port_write(port_write)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Remote miner port: double-flop synchronizers, then shift on each toggle.
    logic [351:0] rem_sh = '0;
    logic [95:0]  rem_val = '0;
    logic [95:0]  out_sh = '0;
    logic [2:0]   rs = '0;
    logic [2:0]   ws = '0;
    logic [1:0]   ss = '0;
    assign port_write = out_sh[7:0];
    always @(posedge clk) begin
        rs <= {rs[1:0], port_rd_clk};
        ws <= {ws[1:0], port_wr_clk};
        ss <= {ss[0], port_wr_start};
        if (rs[2] != rs[1]) rem_sh <= {port_read, rem_sh[351:8]};
        if (ss[1]) out_sh <= rem_val;
        else if (ws[2] != ws[1]) out_sh <= out_sh >> 8;
    end

    // Timeline model: outputs as a function of cycles elapsed since a transfer began.
    typedef enum {M_IDLE, M_SEND, M_FETCH} mmode_t;
    mmode_t       m_mode;
    int           m_t, m_idle, nt;
    logic [351:0] m_work;
    logic [7:0]   m_read;
    logic         m_rd, m_wr, m_ws, m_rv;
    logic [95:0]  m_res;
    logic         m_poll;
    always_comb nt = m_t + 1;
`ifdef WORK_PORT_POLL_EN
    always_comb m_poll = m_idle == PI;
`else
    always_comb m_poll = 1'b0;
`endif

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode <= M_IDLE; m_t <= 0; m_idle <= 0; m_work <= '0; m_read <= '0;
            m_rd <= 1'b0; m_wr <= 1'b0; m_ws <= 1'b0; m_rv <= 1'b0; m_res <= '0;
        end else begin
            m_rv <= 1'b0;
            if (m_mode == M_IDLE) begin
                m_t <= 0;
                if (work_valid) begin
                    m_mode <= M_SEND; m_work <= work; m_read <= work[7:0]; m_idle <= 0;
                end else if (fetch_req || m_poll) begin
                    m_mode <= M_FETCH; m_ws <= 1'b1; m_idle <= 0;
                end else m_idle <= m_idle + 1;
            end else begin
                m_t <= nt;
                m_idle <= 0;
                if (m_mode == M_SEND) begin
                    if (nt == 88 * H) m_mode <= M_IDLE;
                    else begin
                        if (nt % (2 * H) == 0) m_read <= m_work[8 * (nt / (2 * H)) +: 8];
                        if (nt % (2 * H) == H) m_rd <= !m_rd;
                    end
                end else begin
                    m_ws <= nt < H;
                    if (nt == 13 * H + 1) begin
                        m_mode <= M_IDLE; m_res <= rem_val; m_rv <= 1'b1;
                    end else if (nt >= 2 * H + 1 && (nt - 2 * H - 1) % H == 0) m_wr <= !m_wr;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [351:0] got, input logic [351:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        chk("work_ready", work_ready, reset_n && m_mode == M_IDLE);
        chk("busy", busy, m_mode != M_IDLE);
        chk("port_read", port_read, m_read);
        chk("port_rd_clk", port_rd_clk, m_rd);
        chk("port_wr_clk", port_wr_clk, m_wr);
        chk("port_wr_start", port_wr_start, m_ws);
        chk("result_valid", result_valid, m_rv);
        chk("result", result, m_res);
    end

    task automatic send(input logic [351:0] w, output int busy_n, output int tog);
        logic p;
        @(negedge clk); work = w; work_valid = 1'b1;
        @(negedge clk); work_valid = 1'b0;
        busy_n = 0; tog = 0; p = port_rd_clk;
        while (busy && busy_n < 2000) begin
            busy_n++;
            @(negedge clk);
            if (port_rd_clk != p) begin tog++; p = port_rd_clk; end
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_rv(input int c0, output int lat, output int tog);
        logic p;
        int n;
        p = port_wr_clk; n = 0; tog = 0;
        while (!result_valid && n < 3000) begin
            @(negedge clk);
            n++;
            if (port_wr_start) fetch_req = 1'b0;
            if (port_wr_clk != p) begin tog++; p = port_wr_clk; end
        end
        lat = cyc - c0;
    endtask

    logic [351:0] w1, w2, w3, w4, w5;
    int bn, tg, lat, c0, n;

    initial begin
        #1 reset_n = 1'b0;
        for (int k = 0; k < 44; k++) w1[8*k +: 8] = 8'(k);
        for (int k = 0; k < 11; k++) begin
            w2[32*k +: 32] = $urandom; w3[32*k +: 32] = $urandom;
            w4[32*k +: 32] = $urandom; w5[32*k +: 32] = $urandom;
        end
`ifdef WORK_PORT_POLL_EN
        rem_val = 96'h1111_2222_3333_4444_5555_6666;
`endif
        repeat (3) @(negedge clk);
        chk("reset work_ready", work_ready, 1'b0);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("ready after release", work_ready, 1'b1);
`ifdef WORK_PORT_POLL_EN
        begin
            logic [95:0] pv [3];
            int prev;
            pv[0] = 96'h1111_2222_3333_4444_5555_6666;
            pv[1] = 96'hAABBCCDD_11223344_DEADBEEF;
            pv[2] = 96'h0F0E0D0C_0B0A0908_07060504;
            prev = 0;
            for (int i = 0; i < 3; i++) begin
                wait_rv(prev, lat, tg);
                chk("poll result", result, pv[i]);
                if (i > 0) chk("poll period", lat, 154);
                prev = cyc;
                if (i < 2) rem_val = pv[i + 1];
                @(negedge clk);
            end
        end
`else
        send(w1, bn, tg);
        chk("send remote buffer", rem_sh, w1);
        chk("send top byte", rem_sh[351:344], 8'h2B);
        chk("send bottom byte", rem_sh[7:0], 8'h00);
        chk("send rd toggles", tg, 44);
        chk("send rd_clk level", port_rd_clk, 1'b0);
        chk("send busy cycles", bn, 352);

        rem_val = 96'hAABBCCDD_11223344_DEADBEEF;
        @(negedge clk); fetch_req = 1'b1;
        @(negedge clk); fetch_req = 1'b0; c0 = cyc;
        wait_rv(c0, lat, tg);
        chk("fetch result", result, 96'hAABBCCDD_11223344_DEADBEEF);
        chk("fetch latency", lat, 53);
        chk("fetch wr toggles", tg, 11);
        @(negedge clk);
        chk("fetch pulse width", result_valid, 1'b0);

        rem_val = 96'h01234567_89ABCDEF_FEDCBA98;
        @(negedge clk); work = w2; work_valid = 1'b1; fetch_req = 1'b1;
        @(negedge clk); work_valid = 1'b0; c0 = cyc;
        wait_rv(c0, lat, tg);
        chk("collision latency", lat, 406);
        chk("collision result", result, 96'h01234567_89ABCDEF_FEDCBA98);
        chk("collision remote buffer", rem_sh, w2);

        @(negedge clk); fetch_req = 1'b1;
        @(negedge clk); fetch_req = 1'b0; c0 = cyc; work = w3; work_valid = 1'b1;
        n = 0;
        while (!work_ready && n < 200) begin @(negedge clk); n++; end
        chk("backpressure ready delay", n, 53);
        @(negedge clk); work_valid = 1'b0;
        chk("backpressure accepted", busy, 1'b1);
        chk("backpressure accept edge", cyc - c0, 54);
        n = 0;
        while (busy && n < 2000) begin @(negedge clk); n++; end
        repeat (6) @(negedge clk);
        chk("backpressure remote buffer", rem_sh, w3);

        @(negedge clk); work = w4; work_valid = 1'b1;
        @(negedge clk); work_valid = 1'b0;
        repeat (20 * 2 * H + 1) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort port_read", port_read, 8'h00);
        chk("abort busy", busy, 1'b0);
        chk("abort result", result, 96'h0);
        chk("abort wr_clk", port_wr_clk, 1'b0);
        chk("abort rd_clk", port_rd_clk, 1'b0);
        chk("abort ready", work_ready, 1'b0);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        send(w5, bn, tg);
        chk("resend remote buffer", rem_sh, w5);
        chk("resend busy cycles", bn, 352);
`endif
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ztex_work_port_master.md
# ztex_work_port_master

On-FPGA initiator for the byte-serial work/result port used by the single-pipe ZTEX miner top level. It shifts a 352-bit work unit (256-bit midstate plus 96-bit data tail) out one byte per `rd_clk` toggle. It fetches the 96-bit result (hash2, nonce2, golden_nonce) with a `wr_start` load followed by `wr_clk` toggles. It sits in a controller FPGA or a self-test harness and drives the miner's `read`/`rd_clk`/`wr_clk`/`wr_start`/`write` pins in place of the EZ-USB host.

## Interface
- `HOLD`, 4: master clock cycles each strobe level and each data byte is held; must be ≥4 (remote double-flop synchronizer plus shift)
- `POLL_INTERVAL`, 1000000: idle cycles between automatic result fetches (only with `WORK_PORT_POLL_EN`)
- `clk` in 1: sole clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `work` in 352: work unit; [351:96] midstate, [95:0] data
- `work_valid` in 1: work offered
- `work_ready` out 1: work accepted this cycle (valid & ready)
- `fetch_req` in 1: request a result fetch (level; sampled in IDLE)
- `result` out 96: {hash2, nonce2, golden_nonce}, valid when `result_valid`
- `result_valid` out 1: one-cycle pulse, result updated
- `busy` out 1: FSM not in IDLE
- `port_read` out 8: byte presented to remote `read`
- `port_rd_clk` out 1: remote `rd_clk` (toggle per byte)
- `port_wr_clk` out 1: remote `wr_clk` (toggle per byte)
- `port_wr_start` out 1: remote `wr_start`
- `port_write` in 8: remote `write`

## Operation
- States: IDLE, SEND, LOAD, RECV.
- IDLE: `work_ready`=1. `work_valid` → latch `work`, byte count 0, go SEND. Otherwise `fetch_req` (or poll timer expiry) → go LOAD. Both asserted in the same cycle: SEND wins; the fetch stays pending (level).
- SEND: for byte k = 0..43, drive `port_read` = work[8k+7:8k]. Hold `HOLD` cycles, toggle `port_rd_clk`, hold `HOLD` more cycles with `port_read` unchanged. After k=43 → IDLE. Byte order is LSB first, so the remote shift register ends with work[351:344] at its top.
- LOAD: assert `port_wr_start` for `HOLD` cycles, deassert, wait `HOLD` cycles, then go RECV with count 0.
- RECV: sample `port_write` into result_sh[8k+7:8k]. If k<11, toggle `port_wr_clk` and wait `HOLD` cycles before the next sample. After k=11: copy result_sh to `result`, pulse `result_valid`, → IDLE.
- `result` holds its last value until the next completed fetch. A partial fetch never updates it.
- Toggle outputs keep their level across transfers; there is no return-to-zero.
- Counters: 6-bit byte counter, `$clog2(HOLD+1)`-bit hold counter, saturating/reset per phase. None wraps within a transfer.

## Timing
- Reset values: `port_read`=0, `port_rd_clk`=0, `port_wr_clk`=0, `port_wr_start`=0, `result`=0, `result_valid`=0, `busy`=0, `work_ready`=0 during reset, and 1 from the first cycle after release.
- `work_ready` is combinational on state==IDLE. Acceptance and the first byte on `port_read` occur on the same edge.
- Send latency: 44·2·`HOLD` cycles from acceptance to IDLE. With `HOLD`=4 that is 352.
- Fetch latency: 2·`HOLD` + 11·`HOLD` + 1 cycles from leaving IDLE to the `result_valid` pulse. With `HOLD`=4 that is 53.
- `busy` rises on the cycle after acceptance/fetch start and falls on the cycle state returns to IDLE.
- Reset mid-transfer: abort immediately. Strobes are forced to 0, which may produce one spurious remote toggle. The remote work buffer is treated as stale, and the next full 44-byte send overwrites it completely.

## Configuration
- `WORK_PORT_POLL_EN` defined: a 32-bit idle counter runs in IDLE. At `POLL_INTERVAL` it starts a fetch exactly as `fetch_req` does. The counter clears on any exit from IDLE.
- Not defined: fetches start only from `fetch_req`. The counter and `POLL_INTERVAL` are absent and the parameter is ignored.

## Test plan
- Send: `work`=352'h{bytes 00,01,…,2B ascending from LSB}, `HOLD`=4 → remote model shift register equals `work`; `port_rd_clk` toggles 44 times, ending at 0; `busy` high for 352 cycles.
- Fetch: remote model loads 96'hAABBCCDD_11223344_DEADBEEF, `fetch_req` pulsed → `result`=96'hAABBCCDD_11223344_DEADBEEF and one `result_valid` pulse 53 cycles later; `port_wr_clk` toggles 11 times.
- Collision: `work_valid` and `fetch_req` high in the same IDLE cycle → full send completes first, then the fetch; `result_valid` arrives 352+53+1 cycles after the start.
- Reset mid-send at byte 20 → all outputs return to their reset values asynchronously; a following full send produces the correct remote buffer.
- Backpressure: `work_valid` held during a fetch → `work_ready`=0 until IDLE, and the work is accepted on the first IDLE cycle.
- With `WORK_PORT_POLL_EN` and `POLL_INTERVAL`=100: idle, no requests → fetch starts every 100+53+1 cycles and `result` tracks the remote value changes.
